// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target engine: FSM state encoding,
// R/W bit meaning and the default bus address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6
  } i2c_state_e;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h40;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus a previous-value flop that
// yields single-cycle rise/fall strobes. Flops reset to 1 (idle bus level)
// so releasing reset on an idle bus produces no spurious edge.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain and delayed copy of the synchronized level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_engine.sv
// I2C target byte engine: detects START/STOP, matches the 7-bit address,
// ACKs write bytes and serializes read bytes. SDA is only ever pulled low
// (open drain); SCL is never driven.
module i2c_target_engine
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       addressed_o,
  output logic       rw_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i
);

  logic scl_level_s, scl_rise_s, scl_fall_s;
  logic sda_level_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (scl_i),
    .level_o (scl_level_s),
    .rise_o  (scl_rise_s),
    .fall_o  (scl_fall_s)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (sda_i),
    .level_o (sda_level_s),
    .rise_o  (sda_rise_s),
    .fall_o  (sda_fall_s)
  );

  assign start_s = sda_fall_s & scl_level_s;
  assign stop_s  = sda_rise_s & scl_level_s;

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  // full_q: a complete byte has been shifted in (ADDR/WRITE), or the master
  // ACKed a read byte and the next byte must be loaded (READ_ACK).
  logic       full_q, full_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_req_q, rd_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic [7:0] rd_buf_q;

  // Next-state and output decode; bus conditions override SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    full_d      = full_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    if (start_s) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'h00;
      full_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      start_d     = 1'b1;
    end else if (stop_s) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      full_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        ADDR, WRITE: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[6:0], sda_level_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            full_d    = (bit_cnt_q == 3'd7);
          end else if (scl_fall_s && full_q) begin
            full_d = 1'b0;
            if (state_q == WRITE) begin
              wr_data_d  = shift_q;
              wr_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = WRITE_ACK;
            end else if (shift_q[7:1] == TARGET_ADDR) begin
              sda_oe_d    = 1'b1;
              rw_d        = shift_q[0];
              addressed_d = 1'b1;
              rd_req_d    = (shift_q[0] == I2C_RW_READ);
              state_d     = ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end else begin
            state_d = state_q;
          end
        end

        ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 3'd0;
            full_d    = 1'b0;
            if (rw_q == I2C_RW_READ) begin
              shift_d  = rd_buf_q;
              sda_oe_d = ~rd_buf_q[7];
              state_d  = READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WRITE;
            end
          end else begin
            state_d = ADDR_ACK;
          end
        end

        WRITE_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WRITE;
          end else begin
            state_d = WRITE_ACK;
          end
        end

        READ: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = READ_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end else begin
            state_d = READ;
          end
        end

        READ_ACK: begin
          if (scl_rise_s && !full_q) begin
            if (!sda_level_s) begin
              rd_req_d = 1'b1;
              full_d   = 1'b1;
            end else begin
              addressed_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = IDLE;
            end
          end else if (scl_fall_s && full_q) begin
            full_d    = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = rd_buf_q;
            sda_oe_d  = ~rd_buf_q[7];
            state_d   = READ;
          end else begin
            state_d = READ_ACK;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops; reset releases SDA immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      full_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      wr_data_q   <= 8'h00;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      full_q      <= full_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  // Capture the read byte on the clock right after the request pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_buf_q <= 8'h00;
    end else if (rd_req_q) begin
      rd_buf_q <= rd_data_i;
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign start_o     = start_q;
  assign stop_o      = stop_q;
  assign addressed_o = addressed_q;
  assign rw_o        = rw_q;
  assign wr_data_o   = wr_data_q;
  assign wr_valid_o  = wr_valid_q;
  assign rd_req_o    = rd_req_q;

endmodule

// File: tb/tb_i2c_target_engine.sv
// Bench for i2c_target_engine: acts as a bit-banged I2C master on an
// open-drain bus model and checks the target's byte-level behaviour.
module tb_i2c_target_engine;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       start_p, stop_p, addressed, rw, wr_valid, rd_req;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Observed-event records filled by the monitor.
  int         n_start, n_stop, n_rdreq;
  logic [7:0] wr_q[$];
  bit         oe_seen, adr_seen;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_engine dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .start_o     (start_p),
    .stop_o      (stop_p),
    .addressed_o (addressed),
    .rw_o        (rw),
    .wr_data_o   (wr_data),
    .wr_valid_o  (wr_valid),
    .rd_req_o    (rd_req),
    .rd_data_i   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: count pulses and record write bytes, sampled on the falling edge.
  always @(negedge clk) begin
    if (start_p)  n_start++;
    if (stop_p)   n_stop++;
    if (rd_req)   n_rdreq++;
    if (wr_valid) wr_q.push_back(wr_data);
    if (sda_oe)   oe_seen = 1'b1;
    if (addressed) adr_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    n_start = 0; n_stop = 0; n_rdreq = 0;
    wr_q.delete();
    oe_seen = 1'b0; adr_seen = 1'b0;
  endtask

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; wait_q();
    scl_m = 1'b1;
    repeat (4) @(negedge clk);
    s = sda_line;
    repeat (4) @(negedge clk);
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_rd, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
      if (i == 7) rd_data = next_rd;
    end
    clk_bit(~mack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rd_data = 8'h00;
    repeat (4) @(negedge clk);
    total++;
    if ({sda_oe, start_p, stop_p, addressed, rw, wr_valid, rd_req, wr_data} !== 15'h0) begin
      bad++; $display("FAIL reset_outputs: got %b required all 0",
        {sda_oe, start_p, stop_p, addressed, rw, wr_valid, rd_req, wr_data});
    end
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    total++;
    if (n_start + n_stop + n_rdreq + wr_q.size() !== 0 || oe_seen) begin
      bad++; $display("FAIL reset_release_quiet: start=%0d stop=%0d rdreq=%0d wr=%0d oe=%0d required 0",
        n_start, n_stop, n_rdreq, wr_q.size(), oe_seen);
    end
  endtask

  task automatic test_write();
    logic [7:0] exp_q[$];
    logic       ack;
    int         n;
    clear_mon();
    exp_q = {8'h00, 8'hA5};
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
    bus_start();
    write_byte(8'h80, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL write_addr_ack: got %b required 1", ack); end
    foreach (exp_q[i]) begin
      write_byte(exp_q[i], ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL write_data_ack[%0d]: got %b required 1", i, ack); end
    end
    total++;
    if (addressed !== 1'b1 || rw !== 1'b0) begin
      bad++; $display("FAIL write_addressed_rw: got %b%b required 10", addressed, rw);
    end
    bus_stop();
    wait_q();
    total++;
    if (n_start !== 1 || n_stop !== 1) begin
      bad++; $display("FAIL write_start_stop: got start=%0d stop=%0d required 1 1", n_start, n_stop);
    end
    total++;
    if (wr_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL write_count: got %0d required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (wr_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL write_data[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (addressed !== 1'b0 || sda_oe !== 1'b0) begin
      bad++; $display("FAIL write_after_stop: addressed=%b oe=%b required 0 0", addressed, sda_oe);
    end
  endtask

  task automatic test_addr_miss(input logic [6:0] addr);
    logic ack;
    clear_mon();
    bus_start();
    write_byte({addr, 1'b0}, ack);
    write_byte(8'h11, ack);
    bus_stop();
    wait_q();
    total++;
    if (oe_seen || adr_seen || wr_q.size() != 0) begin
      bad++; $display("FAIL miss_%h: oe=%0d addressed=%0d wr=%0d required 0 0 0",
        addr, oe_seen, adr_seen, wr_q.size());
    end
    bus_start();
    write_byte(8'h80, ack);
    bus_stop();
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL miss_follow_ack: got %b required 1", ack); end
  endtask

  task automatic test_read(input bit rnd);
    logic [7:0] q[$];
    logic [7:0] d;
    logic       ack;
    if (rnd) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
    end else begin
      q = {8'h3C, 8'hFF};
    end
    clear_mon();
    rd_data = q[0];
    bus_start();
    write_byte(8'h81, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL read_addr_ack: got %b required 1", ack); end
    foreach (q[k]) begin
      read_byte(k < q.size() - 1, (k < q.size() - 1) ? q[k+1] : 8'($urandom), d);
      total++;
      if (d !== q[k]) begin bad++; $display("FAIL read_data[%0d]: got %h required %h", k, d, q[k]); end
    end
    total++;
    if (sda_oe !== 1'b0 || addressed !== 1'b0 || rw !== 1'b1) begin
      bad++; $display("FAIL read_after_nack: oe=%b addressed=%b rw=%b required 0 0 1", sda_oe, addressed, rw);
    end
    oe_seen = 1'b0;
    write_byte(8'h80, ack);
    total++;
    if (ack !== 1'b0 || oe_seen) begin
      bad++; $display("FAIL read_idle_after_nack: ack=%b oe_seen=%0d required 0 0", ack, oe_seen);
    end
    bus_stop();
    wait_q();
    total++;
    if (n_rdreq !== q.size() || n_start !== 1 || n_stop !== 1) begin
      bad++; $display("FAIL read_pulses: rdreq=%0d start=%0d stop=%0d required %0d 1 1",
        n_rdreq, n_start, n_stop, q.size());
    end
  endtask

  task automatic test_rep_start();
    logic [7:0] b, d;
    logic       ack;
    clear_mon();
    b = 8'($urandom);
    bus_start();
    write_byte(8'h80, ack);
    write_byte(8'h06, ack);
    rd_data = b;
    bus_start();
    write_byte(8'h81, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL rs_addr_ack: got %b required 1", ack); end
    read_byte(1'b0, 8'($urandom), d);
    bus_stop();
    wait_q();
    total++;
    if (d !== b) begin bad++; $display("FAIL rs_read_data: got %h required %h", d, b); end
    total++;
    if (n_start !== 2 || n_rdreq !== 1 || rw !== 1'b1) begin
      bad++; $display("FAIL rs_pulses: start=%0d rdreq=%0d rw=%b required 2 1 1", n_start, n_rdreq, rw);
    end
    total++;
    if (wr_q.size() !== 1 || (wr_q.size() == 1 && wr_q[0] !== 8'h06)) begin
      bad++; $display("FAIL rs_write: count=%0d required 1 byte 06", wr_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic       ack;
    rd_data = {1'b0, 7'($urandom)};
    bus_start();
    write_byte(8'h81, ack);
    total++;
    if (sda_oe !== 1'b1) begin bad++; $display("FAIL rmr_driving_zero: got %b required 1", sda_oe); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sda_oe !== 1'b0) begin bad++; $display("FAIL rmr_async_release: got %b required 0", sda_oe); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    read_byte(1'b1, 8'h00, d);
    write_byte(8'h80, ack);
    total++;
    if (oe_seen || adr_seen) begin
      bad++; $display("FAIL rmr_no_drive: oe=%0d addressed=%0d required 0 0", oe_seen, adr_seen);
    end
    bus_stop();
    bus_start();
    write_byte(8'h80, ack);
    bus_stop();
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL rmr_new_frame_ack: got %b required 1", ack); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack, s;
    clear_mon();
    bus_start();
    write_byte(8'h80, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
    bus_stop();
    wait_q();
    total++;
    if (wr_q.size() !== 0 || n_stop !== 1 || sda_oe !== 1'b0 || addressed !== 1'b0) begin
      bad++; $display("FAIL smb_state: wr=%0d stop=%0d oe=%b addressed=%b required 0 1 0 0",
        wr_q.size(), n_stop, sda_oe, addressed);
    end
    scl_m = 1'b0; wait_q();
    oe_seen = 1'b0;
    write_byte(8'h80, ack);
    total++;
    if (ack !== 1'b0 || oe_seen) begin
      bad++; $display("FAIL smb_idle: ack=%b oe_seen=%0d required 0 0", ack, oe_seen);
    end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_miss(7'h41);
    test_addr_miss(7'($urandom_range(0, 63)));
    test_read(1'b0);
    test_read(1'b1);
    test_rep_start();
    test_reset_mid_read();
    test_stop_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
